// File: rtl/fnd_pkg.sv
`default_nettype none
//==============================================================================
// Package  : fnd_pkg
// Desc     : Shared constants, FSM state encoding and the divider helper for
//            the seven-segment scan front end (fnd_scan_ctrl).
// Revision : 1.0 - initial release
//==============================================================================
package fnd_pkg;

    // Four digits are scanned per frame, selected by a 2-bit index.
    localparam int DIGITS        = 4;
    localparam int SEL_W         = 2;
    localparam int SUM_W_DEFAULT = 9;

    // Frame-synchronous update FSM: IDLE = nothing pending, PEND = a value
    // waits for the next frame boundary.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    // Clock cycles spent on each digit.
    function automatic int calc_div(input int clk_hz, input int scan_hz);
        return clk_hz / scan_hz;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fnd_scan_ctrl_if.sv
`default_nettype none
//==============================================================================
// Interface: fnd_scan_ctrl_if
// Desc     : valid/ready handshake carrying new adder results into the scan
//            controller. master = adder side, slave = fnd_scan_ctrl.
// Revision : 1.0 - initial release
//==============================================================================
interface fnd_scan_ctrl_if
    import fnd_pkg::*;
#(
    parameter int SUM_W = SUM_W_DEFAULT
);
    logic [SUM_W-1:0] sum_in;
    logic             sum_valid;
    logic             sum_ready;

    modport master (
        output sum_in,
        output sum_valid,
        input  sum_ready
    );

    modport slave (
        input  sum_in,
        input  sum_valid,
        output sum_ready
    );
endinterface
`default_nettype wire

// File: rtl/fnd_scan_ctrl_tick_gen.sv
`default_nettype none
//==============================================================================
// Module   : fnd_tick_gen
// Desc     : Free-running 0..DIV-1 divider; tick is high during the last count
//            so the consumer advances once every DIV cycles.
// Revision : 1.0 - initial release
//==============================================================================
module fnd_tick_gen #(
    parameter int DIV = 4
) (
    input  wire logic clk,
    input  wire logic reset_n,
    output logic      tick
);
    localparam int             CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] div_cnt;

    // Divider counter, wraps after the terminal count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
        end else if (div_cnt == CNT_MAX) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = (div_cnt == CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/fnd_scan_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : fnd_scan_ctrl
// Desc     : Digit-scan sequencer and display-value register feeding
//            fnd_controller. Steps seg_sel 0..3 every DIV cycles, pulses
//            frame_start after each 3->0 wrap, and latches adder results
//            taken over a valid/ready handshake.
// Config   : FND_FRAME_SYNC_EN defined   -> new values are held in a pending
//                                           register and shown only at the
//                                           next frame boundary.
//            FND_FRAME_SYNC_EN undefined -> every transfer updates sum on the
//                                           same edge; always ready.
// Revision : 1.0 - initial release
//==============================================================================
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int SCAN_HZ = 1000,
    parameter int SUM_W   = SUM_W_DEFAULT
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    fnd_scan_ctrl_if.slave   up,
    output logic [SEL_W-1:0] seg_sel,
    output logic [SUM_W-1:0] sum,
    output logic             frame_start
);
    localparam int               DIV      = calc_div(CLK_HZ, SCAN_HZ);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(DIGITS - 1);

    generate
        if (DIV < 2) begin : g_div_check
            $error("fnd_scan_ctrl: CLK_HZ/SCAN_HZ must be at least 2");
        end
    endgenerate

    logic tick;
    logic wrap;
    logic ready;
    logic xfer;

    fnd_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    assign wrap         = tick && (seg_sel == LAST_SEL);
    assign xfer         = up.sum_valid && ready;
    assign up.sum_ready = ready;

    // Digit select advances once per tick; frame_start flags the cycle after a wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_sel     <= '0;
            frame_start <= 1'b0;
        end else begin
            if (tick) begin
                seg_sel <= seg_sel + 1'b1;
            end
            frame_start <= wrap;
        end
    end

`ifdef FND_FRAME_SYNC_EN

    state_t           state;
    state_t           state_nx;
    logic [SUM_W-1:0] pend;
    logic             show_pend;

    // Next state and handshake: ready while empty, or on the wrap edge when
    // the pending value is about to move to the display.
    always_comb begin
        state_nx  = state;
        show_pend = 1'b0;
        ready     = (state == IDLE) || wrap;
        case (state)
            IDLE: begin
                if (xfer) begin
                    state_nx = PEND;
                end
            end
            PEND: begin
                if (wrap) begin
                    show_pend = 1'b1;
                    state_nx  = xfer ? PEND : IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, pending slot and display register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            pend  <= '0;
            sum   <= '0;
        end else begin
            state <= state_nx;
            if (show_pend) begin
                sum <= pend;
            end
            if (xfer) begin
                pend <= up.sum_in;
            end
        end
    end

`else

    assign ready = 1'b1;

    // Immediate update: every transfer goes straight to the display.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum <= '0;
        end else if (xfer) begin
            sum <= up.sum_in;
        end
    end

`endif

endmodule
`default_nettype wire

// File: tb/tb_fnd_scan_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : tb_fnd_scan_ctrl
// Desc     : Directed self-checking bench for fnd_scan_ctrl with DIV = 4
//            (CLK_HZ = 8, SCAN_HZ = 2, one frame = 16 cycles). Cycle 0 is the
//            cycle right after reset release; outputs are sampled on the
//            falling edge. Mode follows FND_FRAME_SYNC_EN.
// Revision : 1.0 - initial release
//==============================================================================
module tb_fnd_scan_ctrl;
    localparam int SUM_W = 9;

    logic             clk;
    logic             reset_n;
    logic [1:0]       seg_sel;
    logic [SUM_W-1:0] sum;
    logic             frame_start;

    int tests;
    int fails;
    int cyc;

    fnd_scan_ctrl_if #(.SUM_W(SUM_W)) bus ();

    fnd_scan_ctrl #(
        .CLK_HZ  (8),
        .SCAN_HZ (2),
        .SUM_W   (SUM_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .up          (bus.slave),
        .seg_sel     (seg_sel),
        .sum         (sum),
        .frame_start (frame_start)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    // Hold reset two edges, release just after a rising edge, park in cycle 0.
    task automatic do_reset();
        bus.sum_valid = 1'b0;
        bus.sum_in    = '0;
        reset_n       = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        cyc = 0;
    endtask

    task automatic test_reset();
        bus.sum_valid = 1'b0;
        bus.sum_in    = '0;
        reset_n       = 1'b0;
        #2;
        tests++;
        if (seg_sel !== 2'd0 || sum !== 9'd0 || frame_start !== 1'b0 || bus.sum_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_state: seg_sel=%0d sum=%0d fs=%b ready=%b, want 0 0 0 1",
                     seg_sel, sum, frame_start, bus.sum_ready);
        end
        do_reset();
        tests++;
        if (seg_sel !== 2'd0 || sum !== 9'd0 || frame_start !== 1'b0) begin
            fails++;
            $display("FAIL reset_cycle0: seg_sel=%0d sum=%0d fs=%b, want 0 0 0",
                     seg_sel, sum, frame_start);
        end
    endtask

    // Idle scan over 40 cycles: digit held 4 cycles, frame_start at 16 and 32.
    task automatic test_scan();
        logic [1:0] exp_sel;
        logic       exp_fs;
        do_reset();
        for (int c = 0; c <= 40; c++) begin
            exp_sel = 2'((c / 4) % 4);
            exp_fs  = (c == 16) || (c == 32);
            tests++;
            if (seg_sel !== exp_sel) begin
                fails++;
                $display("FAIL scan_sel c=%0d: got %0d want %0d", c, seg_sel, exp_sel);
            end
            tests++;
            if (frame_start !== exp_fs) begin
                fails++;
                $display("FAIL scan_fs c=%0d: got %b want %b", c, frame_start, exp_fs);
            end
            tests++;
            if (sum !== 9'd0) begin
                fails++;
                $display("FAIL scan_sum c=%0d: got %0d want 0", c, sum);
            end
            step();
        end
    endtask

`ifdef FND_FRAME_SYNC_EN

    // 300 accepted at cycle 5; later offers while not ready must be ignored.
    task automatic test_frame_sync();
        logic             exp_rdy;
        logic [SUM_W-1:0] exp_sum;
        do_reset();
        for (int c = 0; c <= 33; c++) begin
            bus.sum_valid = (c == 5) || (c == 8) || (c == 9);
            bus.sum_in    = (c == 5) ? 9'd300 : 9'h0F0;
            exp_rdy = (c <= 5) || (c >= 15);
            exp_sum = (c >= 16) ? 9'd300 : 9'd0;
            tests++;
            if (bus.sum_ready !== exp_rdy) begin
                fails++;
                $display("FAIL fsync_ready c=%0d: got %b want %b", c, bus.sum_ready, exp_rdy);
            end
            tests++;
            if (sum !== exp_sum) begin
                fails++;
                $display("FAIL fsync_sum c=%0d: got %0d want %0d", c, sum, exp_sum);
            end
            step();
        end
        bus.sum_valid = 1'b0;
    endtask

    // 300 pending, 511 offered exactly on the wrap edge at cycle 15.
    task automatic test_wrap_xfer();
        logic             exp_rdy;
        logic [SUM_W-1:0] exp_sum;
        do_reset();
        for (int c = 0; c <= 33; c++) begin
            bus.sum_valid = (c == 5) || (c == 15);
            bus.sum_in    = (c == 15) ? 9'd511 : 9'd300;
            exp_rdy = (c <= 5) || (c == 15) || (c >= 31);
            exp_sum = (c >= 32) ? 9'd511 : ((c >= 16) ? 9'd300 : 9'd0);
            tests++;
            if (bus.sum_ready !== exp_rdy) begin
                fails++;
                $display("FAIL wrapx_ready c=%0d: got %b want %b", c, bus.sum_ready, exp_rdy);
            end
            tests++;
            if (sum !== exp_sum) begin
                fails++;
                $display("FAIL wrapx_sum c=%0d: got %0d want %0d", c, sum, exp_sum);
            end
            if (c == 32) begin
                tests++;
                if (frame_start !== 1'b1) begin
                    fails++;
                    $display("FAIL wrapx_fs c=32: got %b want 1", frame_start);
                end
            end
            step();
        end
        bus.sum_valid = 1'b0;
    endtask

    // 123 pending, reset mid-frame: it must never reach the display.
    task automatic test_reset_mid();
        do_reset();
        while (cyc < 9) begin
            bus.sum_valid = (cyc == 5);
            bus.sum_in    = 9'd123;
            step();
        end
        bus.sum_valid = 1'b0;
        tests++;
        if (bus.sum_ready !== 1'b0 || seg_sel !== 2'd2) begin
            fails++;
            $display("FAIL rstmid_pre: ready=%b seg_sel=%0d, want 0 2", bus.sum_ready, seg_sel);
        end
        reset_n = 1'b0;
        #1;
        tests++;
        if (seg_sel !== 2'd0 || sum !== 9'd0 || bus.sum_ready !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_async: seg_sel=%0d sum=%0d ready=%b, want 0 0 1",
                     seg_sel, sum, bus.sum_ready);
        end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        cyc = 0;
        for (int c = 0; c <= 40; c++) begin
            tests++;
            if (sum !== 9'd0 || bus.sum_ready !== 1'b1) begin
                fails++;
                $display("FAIL rstmid_post c=%0d: sum=%0d ready=%b, want 0 1", c, sum, bus.sum_ready);
            end
            step();
        end
    endtask

`else

    // 255 accepted at cycle 5 shows from cycle 6; ready never drops.
    task automatic test_immediate();
        logic [SUM_W-1:0] exp_sum;
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            bus.sum_valid = (c == 5);
            bus.sum_in    = 9'd255;
            exp_sum = (c >= 6) ? 9'd255 : 9'd0;
            tests++;
            if (bus.sum_ready !== 1'b1) begin
                fails++;
                $display("FAIL imm_ready c=%0d: got %b want 1", c, bus.sum_ready);
            end
            tests++;
            if (sum !== exp_sum) begin
                fails++;
                $display("FAIL imm_sum c=%0d: got %0d want %0d", c, sum, exp_sum);
            end
            step();
        end
        bus.sum_valid = 1'b0;
    endtask

    // Values on consecutive cycles, including all-ones; idle data is ignored.
    task automatic test_back_to_back();
        logic [SUM_W-1:0] vals [4];
        logic [SUM_W-1:0] exp_sum;
        vals[0] = 9'h001;
        vals[1] = 9'h1FF;
        vals[2] = 9'h0AA;
        vals[3] = 9'h155;
        do_reset();
        for (int c = 0; c <= 10; c++) begin
            bus.sum_valid = (c >= 2) && (c <= 5);
            bus.sum_in    = ((c >= 2) && (c <= 5)) ? vals[c-2] : 9'h0F0;
            if (c <= 2)      exp_sum = 9'd0;
            else if (c <= 6) exp_sum = vals[c-3];
            else             exp_sum = vals[3];
            tests++;
            if (sum !== exp_sum) begin
                fails++;
                $display("FAIL b2b_sum c=%0d: got %h want %h", c, sum, exp_sum);
            end
            step();
        end
        bus.sum_valid = 1'b0;
    endtask

    // Reset mid-frame clears sum and seg_sel immediately, then scan restarts.
    task automatic test_reset_mid();
        do_reset();
        while (cyc < 9) begin
            bus.sum_valid = (cyc == 1);
            bus.sum_in    = 9'h1A5;
            step();
        end
        bus.sum_valid = 1'b0;
        tests++;
        if (sum !== 9'h1A5 || seg_sel !== 2'd2) begin
            fails++;
            $display("FAIL rstmid_pre: sum=%h seg_sel=%0d, want 1a5 2", sum, seg_sel);
        end
        reset_n = 1'b0;
        #1;
        tests++;
        if (seg_sel !== 2'd0 || sum !== 9'd0 || frame_start !== 1'b0 || bus.sum_ready !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_async: seg_sel=%0d sum=%0d fs=%b ready=%b, want 0 0 0 1",
                     seg_sel, sum, frame_start, bus.sum_ready);
        end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        cyc = 0;
        for (int c = 0; c <= 5; c++) begin
            tests++;
            if (seg_sel !== 2'(c / 4) || sum !== 9'd0) begin
                fails++;
                $display("FAIL rstmid_post c=%0d: seg_sel=%0d sum=%0d, want %0d 0",
                         c, seg_sel, sum, c / 4);
            end
            step();
        end
    endtask

`endif

    initial begin
        tests         = 0;
        fails         = 0;
        cyc           = 0;
        reset_n       = 1'b0;
        bus.sum_valid = 1'b0;
        bus.sum_in    = '0;
        test_reset();
        test_scan();
`ifdef FND_FRAME_SYNC_EN
        test_frame_sync();
        test_wrap_xfer();
        test_reset_mid();
`else
        test_immediate();
        test_back_to_back();
        test_reset_mid();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
